// File: rtl/cu_pkg.sv
// Shared encodings for the cu_seq instruction sequencer: opcodes, ALU selects,
// FSM states and instruction classes.
package cu_pkg;

   localparam logic [3:0] OPC_MOV = 4'b0001;
   localparam logic [3:0] OPC_ADD = 4'b0010;
   localparam logic [3:0] OPC_SUB = 4'b0011;
   localparam logic [3:0] OPC_AND = 4'b0100;
   localparam logic [3:0] OPC_OR  = 4'b0101;
   localparam logic [3:0] OPC_XOR = 4'b0110;
   localparam logic [3:0] OPC_NOT = 4'b0111;
   localparam logic [3:0] OPC_SHL = 4'b1000;
   localparam logic [3:0] OPC_SHR = 4'b1001;
   localparam logic [3:0] OPC_LT  = 4'b1010;
   localparam logic [3:0] OPC_EQ  = 4'b1011;
   localparam logic [3:0] OPC_MVI = 4'b1100;

   // ALU select is the ALU-class opcode minus one
   localparam logic [3:0] ALU_NOP = 4'd0;
   localparam logic [3:0] ALU_ADD = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd2;
   localparam logic [3:0] ALU_AND = 4'd3;
   localparam logic [3:0] ALU_OR  = 4'd4;
   localparam logic [3:0] ALU_XOR = 4'd5;
   localparam logic [3:0] ALU_NOT = 4'd6;
   localparam logic [3:0] ALU_SHL = 4'd7;
   localparam logic [3:0] ALU_SHR = 4'd8;
   localparam logic [3:0] ALU_LT  = 4'd9;
   localparam logic [3:0] ALU_EQ  = 4'd10;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_CAP  = 3'd3,
      ST_WB   = 3'd4,
      ST_DONE = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      CLS_BIN = 3'd0,
      CLS_UNA = 3'd1,
      CLS_MOV = 3'd2,
      CLS_MVI = 3'd3,
      CLS_ILL = 3'd4
   } cls_t;

endpackage

// File: rtl/cu_decode.sv
// Opcode decoder: instruction class, ALU select and legality, all combinational.
module cu_decode
   import cu_pkg::*;
#(
   parameter int OP_W = 4
)(
   input  logic [OP_W-1:0] opcode,
   output logic [2:0]      cls,
   output logic [OP_W-1:0] alu_op,
   output logic            legal
);

   always_comb begin
      cls    = CLS_ILL;
      alu_op = '0;
      legal  = 1'b0;
      case (opcode)
         OP_W'(OPC_MOV): begin
            cls   = CLS_MOV;
            legal = 1'b1;
         end
         OP_W'(OPC_ADD), OP_W'(OPC_SUB), OP_W'(OPC_AND), OP_W'(OPC_OR),
         OP_W'(OPC_XOR), OP_W'(OPC_LT), OP_W'(OPC_EQ): begin
            cls    = CLS_BIN;
            alu_op = opcode - OP_W'(1);
            legal  = 1'b1;
         end
         OP_W'(OPC_NOT), OP_W'(OPC_SHL), OP_W'(OPC_SHR): begin
            cls    = CLS_UNA;
            alu_op = opcode - OP_W'(1);
            legal  = 1'b1;
         end
         OP_W'(OPC_MVI): begin
            cls   = CLS_MVI;
            legal = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/cu_seq.sv
// Multi-cycle register-to-register sequencer driving an external sync RAM and a
// combinational ALU; one instruction per start/done handshake.
//
//   state   | meaning
//   IDLE    | waiting for start, latches decoded fields
//   RD_A    | read dest register (first operand)
//   RD_B    | read src register; binary ops capture operand A
//   CAP     | capture second operand (or the unary operand)
//   WB      | write result back to dest
//   DONE    | done pulse, err valid
module cu_seq
   import cu_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6,
   parameter int OP_W   = 4
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [OP_W-1:0]   opcode,
   input  logic [ADDR_W-1:0] dest,
   input  logic [ADDR_W-1:0] src,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              zero_flag,
   output logic              ram_read,
   output logic              ram_write,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   input  logic [DATA_W-1:0] alu_result,
   input  logic              alu_zero
);

   state_t            state, state_nxt;
   cls_t              cls_q;
   logic [OP_W-1:0]   alu_op_q;
   logic [ADDR_W-1:0] dest_q, src_q;

   logic [2:0]        dec_cls;
   logic [OP_W-1:0]   dec_alu_op;
   logic              dec_legal;

   cu_decode #(.OP_W(OP_W)) u_decode (
      .opcode (opcode),
      .cls    (dec_cls),
      .alu_op (dec_alu_op),
      .legal  (dec_legal)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         cls_q     <= CLS_BIN;
         alu_op_q  <= '0;
         dest_q    <= '0;
         src_q     <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         zero_flag <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cls_q    <= cls_t'(dec_cls);
                  alu_op_q <= dec_alu_op;
                  dest_q   <= dest;
                  src_q    <= src;
               end
            end
            ST_RD_B: begin
               if (cls_q == CLS_BIN)
                  alu_a <= ram_rdata;
            end
            ST_CAP: begin
               if (cls_q == CLS_UNA) begin
                  alu_a <= ram_rdata;
                  alu_b <= '0;
               end else begin
                  alu_b <= ram_rdata;
               end
            end
            ST_WB: begin
               // MOV and MVI leave the flag alone
               if (cls_q == CLS_BIN || cls_q == CLS_UNA)
                  zero_flag <= alu_zero;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      busy      = (state != ST_IDLE);
      done      = 1'b0;
      err       = 1'b0;
      ram_read  = 1'b0;
      ram_write = 1'b0;
      ram_addr  = '0;
      ram_wdata = '0;
      alu_op    = '0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               if (!dec_legal) begin
                  state_nxt = ST_DONE;
               end else begin
                  case (cls_t'(dec_cls))
                     CLS_BIN, CLS_UNA: state_nxt = ST_RD_A;
                     CLS_MOV:          state_nxt = ST_RD_B;
                     CLS_MVI:          state_nxt = ST_WB;
                     default:          state_nxt = ST_DONE;
                  endcase
               end
            end
         end
         ST_RD_A: begin
            ram_read  = 1'b1;
            ram_addr  = dest_q;
            state_nxt = (cls_q == CLS_BIN) ? ST_RD_B : ST_CAP;
         end
         ST_RD_B: begin
            ram_read  = 1'b1;
            ram_addr  = src_q;
            state_nxt = ST_CAP;
         end
         ST_CAP: state_nxt = ST_WB;
         ST_WB: begin
            // a reset landing on the write cycle must not corrupt the register file
            ram_write = !rst;
            ram_addr  = dest_q;
            state_nxt = ST_DONE;
            case (cls_q)
               CLS_MOV: ram_wdata = alu_b;
               CLS_MVI: ram_wdata = DATA_W'(src_q);
               default: begin
                  ram_wdata = alu_result;
                  alu_op    = alu_op_q;
               end
            endcase
         end
         ST_DONE: begin
            done      = 1'b1;
            err       = (cls_q == CLS_ILL);
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: behavioural RAM/ALU, directed instructions, queue scoreboard.
module tb_cu_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  opcode = '0;
   logic [5:0]  dest = '0, src = '0;
   logic        busy, done, err, zero_flag, ram_read, ram_write, alu_zero;
   logic [5:0]  ram_addr;
   logic [15:0] ram_wdata, ram_rdata, alu_a, alu_b, alu_result;
   logic [3:0]  alu_op;

   always #5 clk = ~clk;

   cu_seq #(.DATA_W(16), .ADDR_W(6), .OP_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .dest(dest), .src(src),
      .busy(busy), .done(done), .err(err), .zero_flag(zero_flag),
      .ram_read(ram_read), .ram_write(ram_write), .ram_addr(ram_addr),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .alu_op(alu_op),
      .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result), .alu_zero(alu_zero)
   );

   // register-file RAM with a side port for preloading
   logic [15:0] mem [64];
   logic        poke_en = 1'b0;
   logic [5:0]  poke_addr = '0;
   logic [15:0] poke_data = '0;
   always @(posedge clk) begin
      if (poke_en)   mem[poke_addr] <= poke_data;
      if (ram_write) mem[ram_addr]  <= ram_wdata;
      if (ram_read)  ram_rdata      <= mem[ram_addr];
   end

   always_comb begin
      case (alu_op)
         4'd1:    alu_result = alu_a + alu_b;
         4'd2:    alu_result = alu_a - alu_b;
         4'd3:    alu_result = alu_a & alu_b;
         4'd4:    alu_result = alu_a | alu_b;
         4'd5:    alu_result = alu_a ^ alu_b;
         4'd6:    alu_result = ~alu_a;
         4'd7:    alu_result = alu_a << 1;
         4'd8:    alu_result = alu_a >> 1;
         4'd9:    alu_result = {15'd0, alu_a < alu_b};
         4'd10:   alu_result = {15'd0, alu_a == alu_b};
         default: alu_result = '0;
      endcase
      alu_zero = (alu_result == 16'd0);
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   logic rst_seen = 1'b0;
   always @(posedge clk) rst_seen <= rst;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int          t;
      int          lat;
      logic        err;
      int          nrd;
      logic [5:0]  rd0;
      logic [5:0]  rd1;
      int          nwr;
      logic [5:0]  wa;
      logic [15:0] wd;
      logic        zero;
   } exp_t;
   exp_t sb[$];

   int          acc_busy = 0, acc_rd = 0, acc_wr = 0, acc_wc = 0;
   logic [5:0]  acc_rd0 = '0, acc_rd1 = '0, acc_wa = '0;
   logic [15:0] acc_wd = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_seen) begin
         chk("rst_ctrl", 32'({busy, done, err, zero_flag, ram_read, ram_write, alu_op}), 32'd0);
         chk("rst_addr_wdata", 32'({ram_addr, ram_wdata}), 32'd0);
         chk("rst_alu_a", 32'(alu_a), 32'd0);
         chk("rst_alu_b", 32'(alu_b), 32'd0);
      end
      if (rst) begin
         chk("write_in_reset", 32'(ram_write), 32'd0);
         acc_busy = 0; acc_rd = 0; acc_wr = 0;
      end else begin
         if (busy) acc_busy++;
         if (ram_read) begin
            if (acc_rd == 0) acc_rd0 = ram_addr;
            if (acc_rd == 1) acc_rd1 = ram_addr;
            acc_rd++;
         end
         if (ram_write) begin
            acc_wr++;
            acc_wa = ram_addr;
            acc_wd = ram_wdata;
            acc_wc = cyc;
         end
         if (done) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 32'(done), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("done_latency", 32'(cyc - e.t), 32'(e.lat));
               chk("err", 32'(err), 32'(e.err));
               chk("zero_flag", 32'(zero_flag), 32'(e.zero));
               chk("busy_cycles", 32'(acc_busy), 32'(e.lat));
               chk("read_count", 32'(acc_rd), 32'(e.nrd));
               if (e.nrd >= 1) chk("read0_addr", 32'(acc_rd0), 32'(e.rd0));
               if (e.nrd >= 2) chk("read1_addr", 32'(acc_rd1), 32'(e.rd1));
               chk("write_count", 32'(acc_wr), 32'(e.nwr));
               if (e.nwr == 1) begin
                  chk("write_addr", 32'(acc_wa), 32'(e.wa));
                  chk("write_data", 32'(acc_wd), 32'(e.wd));
                  chk("write_latency", 32'(acc_wc - e.t), 32'(e.lat - 1));
               end
            end
            acc_busy = 0; acc_rd = 0; acc_wr = 0;
         end
      end
   end

   // all stimulus tasks start and end #1 after a rising edge
   task automatic poke(input logic [5:0] a, input logic [15:0] d);
      poke_en = 1'b1; poke_addr = a; poke_data = d;
      @(posedge clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic issue(input logic [3:0] op, input logic [5:0] d, input logic [5:0] s,
                        input int lat, input logic e_err, input int nrd,
                        input logic [5:0] rd0, input logic [5:0] rd1, input int nwr,
                        input logic [15:0] wd, input logic zero, input bit track);
      exp_t e;
      start = 1'b1; opcode = op; dest = d; src = s;
      e.t = cyc; e.lat = lat; e.err = e_err; e.nrd = nrd; e.rd0 = rd0; e.rd1 = rd1;
      e.nwr = nwr; e.wa = d; e.wd = wd; e.zero = zero;
      if (track) sb.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int i = 0;
      do begin
         @(posedge clk);
         i++;
      end while (sb.size() != 0 && i < 40);
      #1;
      chk("pending_after_wait", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      poke(6'd3, 16'h0010);
      poke(6'd7, 16'h0005);
      poke(6'd2, 16'h00FF);
      rst = 1'b0;
      @(posedge clk); #1;

      //    op       d   s      lat err nrd rd0 rd1 nwr wdata     zero
      issue(4'b1100, 5, 6'h2A, 2, 0, 0, 0, 0, 1, 16'h002A, 0, 1); wait_done();
      issue(4'b0010, 3, 7,     5, 0, 2, 3, 7, 1, 16'h0015, 0, 1); wait_done();
      poke(6'd3, 16'h1234);
      issue(4'b0011, 3, 3,     5, 0, 2, 3, 3, 1, 16'h0000, 1, 1); wait_done();
      issue(4'b0001, 4, 3,     4, 0, 1, 3, 0, 1, 16'h0000, 1, 1); wait_done();
      issue(4'b0111, 2, 0,     4, 0, 1, 2, 0, 1, 16'hFF00, 0, 1); wait_done();
      issue(4'b0001, 4, 2,     4, 0, 1, 2, 0, 1, 16'hFF00, 0, 1); wait_done();
      issue(4'b1110, 6, 6,     1, 1, 0, 0, 0, 0, 16'h0000, 0, 1); wait_done();
      issue(4'b0011, 5, 5,     5, 0, 2, 5, 5, 1, 16'h0000, 1, 1); wait_done();
      issue(4'b0000, 1, 1,     1, 1, 0, 0, 0, 0, 16'h0000, 1, 1); wait_done();

      // ADD abandoned by a reset in its WB cycle: R3 must keep 0x0010
      poke(6'd3, 16'h0010);
      issue(4'b0010, 3, 7,     5, 0, 2, 3, 7, 1, 16'h0015, 0, 0);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue(4'b0001, 8, 3,     4, 0, 1, 3, 0, 1, 16'h0010, 0, 1); wait_done();

      // start pulsed while busy is ignored; start right after DONE is taken
      issue(4'b0010, 3, 7,     5, 0, 2, 3, 7, 1, 16'h0015, 0, 1);
      @(posedge clk); #1;
      start = 1'b1; opcode = 4'b1100; dest = 6'd1; src = 6'd1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      issue(4'b0110, 3, 7,     5, 0, 2, 3, 7, 1, 16'h0010, 0, 1); wait_done();

      issue(4'b1000, 7, 0,     4, 0, 1, 7, 0, 1, 16'h000A, 0, 1); wait_done();
      issue(4'b1001, 2, 0,     4, 0, 1, 2, 0, 1, 16'h7F80, 0, 1); wait_done();
      issue(4'b1010, 7, 2,     5, 0, 2, 7, 2, 1, 16'h0001, 0, 1); wait_done();
      issue(4'b1011, 2, 7,     5, 0, 2, 2, 7, 1, 16'h0000, 1, 1); wait_done();
      issue(4'b1100, 9, 6'h3F, 2, 0, 0, 0, 0, 1, 16'h003F, 1, 1); wait_done();

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
